// File: rtl/pool_arbiter.sv
// Shared-pool allocation controller: four requesters draw all-or-nothing amounts from one pool.
// A round-robin arbiter serves one request per three cycles; holdings and free count are registered.
module pool_arbiter #(
    parameter int unsigned CAPACITY = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] amt0,
    input  logic [3:0] amt1,
    input  logic [3:0] amt2,
    input  logic [3:0] amt3,
    input  logic [3:0] rel,
    output logic [3:0] ack,
    output logic       granted,
    output logic [3:0] held0,
    output logic [3:0] held1,
    output logic [3:0] held2,
    output logic [3:0] held3,
    output logic [3:0] free,
    output logic       busy
);

    localparam logic [3:0] CapVal = 4'(CAPACITY);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_win, w_win_nxt;
    logic [3:0] r_amt, w_amt_nxt;
    logic [3:0] r_held [4];
    logic [3:0] w_held_nxt [4];
    logic [3:0] r_free, w_free_nxt;
    logic [3:0] r_ack, w_ack_nxt;
    logic       r_granted, w_granted_nxt;

    logic [3:0] w_amt_in [4];
    logic [1:0] w_idx;
    logic [1:0] w_sel;
    logic       w_found;
    logic       w_grant;
    logic [3:0] w_rel_sum;

    assign w_amt_in[0] = amt0;
    assign w_amt_in[1] = amt1;
    assign w_amt_in[2] = amt2;
    assign w_amt_in[3] = amt3;

    // Decision uses the registered free count, so a same-edge release never enlarges a grant.
    assign w_grant = (r_amt != 4'd0) && (r_amt <= r_free);

    // Round-robin search starting one past the last winner, wrapping back to the pointer itself.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Next-state logic: FSM sequencing, releases in any state, grant bookkeeping on EVAL exit.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_win_nxt     = r_win;
        w_amt_nxt     = r_amt;
        w_ack_nxt     = 4'd0;
        w_granted_nxt = 1'b0;
        w_rel_sum     = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_held_nxt[i] = r_held[i];
            if (rel[i]) begin
                w_rel_sum     = w_rel_sum + r_held[i];
                w_held_nxt[i] = 4'd0;
            end
        end
        w_free_nxt = r_free + w_rel_sum;

        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_nxt = StEval;
                    w_win_nxt   = w_sel;
                    w_amt_nxt   = w_amt_in[w_sel];
                    w_ptr_nxt   = w_sel;
                end
            end
            StEval: begin
                w_state_nxt   = StDone;
                w_ack_nxt     = 4'b0001 << r_win;
                w_granted_nxt = w_grant;
                if (w_grant) begin
                    // A same-edge release of the winner zeroes the base before adding.
                    w_held_nxt[r_win] = w_held_nxt[r_win] + r_amt;
                    w_free_nxt        = w_free_nxt - r_amt;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State register: FSM state, arbitration context, counters and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_ptr     <= 2'd3;
            r_win     <= 2'd0;
            r_amt     <= 4'd0;
            r_free    <= CapVal;
            r_ack     <= 4'd0;
            r_granted <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_held[i] <= 4'd0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_amt     <= w_amt_nxt;
            r_free    <= w_free_nxt;
            r_ack     <= w_ack_nxt;
            r_granted <= w_granted_nxt;
            for (int i = 0; i < 4; i++) begin
                r_held[i] <= w_held_nxt[i];
            end
        end
    end

    assign ack     = r_ack;
    assign granted = r_granted;
    assign held0   = r_held[0];
    assign held1   = r_held[1];
    assign held2   = r_held[2];
    assign held3   = r_held[3];
    assign free    = r_free;
    assign busy    = (r_state != StIdle);

endmodule
